// File: rtl/odd_seq_checker_pkg.sv
// Shared types and constants for the odd up-counter sequence checker.
// The legal sequence is 1 -> 3 -> 5 -> 7 -> 1, stepping by two in three bits.
package odd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } state_t;

    localparam logic [2:0] ODD_STEP  = 3'd2;
    localparam logic [2:0] ODD_FIRST = 3'd1;
    localparam logic [2:0] ODD_LAST  = 3'd7;

    // Three-bit add, so 7 rolls over to 1 naturally.
    function automatic logic [2:0] expectedNext(input logic [2:0] lastVal);
        return lastVal + ODD_STEP;
    endfunction

endpackage

// File: rtl/odd_seq_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/odd_seq_checker.sv
// Locks onto the odd counter sequence 1,3,5,7,1 and flags deviations once locked.
// Keeps saturating counts of completed wraps and of rejected samples.
module odd_seq_checker
    import odd_seq_pkg::*;
#(
    parameter int LOCK_LEN = 3,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        din,
    input  logic              din_valid,
    input  logic              clr_stats,
    output logic              locked,
    output logic              seq_err,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [2:0]        last_val
);

    localparam int GOOD_W = $clog2(LOCK_LEN + 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [2:0]        r_lastVal;
    logic [2:0]        w_nextLastVal;
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_nextGood;
    logic              r_seqErr;
    logic              w_nextSeqErr;
    logic              w_wrapInc;
    logic              w_errInc;
    logic [2:0]        w_expected;
    logic              w_match;
    logic              w_odd;
    logic              w_goodDone;

    assign w_expected = expectedNext(r_lastVal);
    assign w_match    = (din == w_expected);
    assign w_odd      = din[0];
    assign w_goodDone = ((int'(r_good) + 1) == LOCK_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_lastVal <= '0;
            r_good    <= '0;
            r_seqErr  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_lastVal <= w_nextLastVal;
            r_good    <= w_nextGood;
            r_seqErr  <= w_nextSeqErr;
        end
    end

    // Every valid sample except an even one in IDLE is stored into last_val.
    always_comb begin
        w_nextState   = r_state;
        w_nextLastVal = r_lastVal;
        w_nextGood    = r_good;
        w_nextSeqErr  = 1'b0;
        w_wrapInc     = 1'b0;
        w_errInc      = 1'b0;
        if (din_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_odd) begin
                        w_nextLastVal = din;
                        w_nextGood    = '0;
                        w_nextState   = SYNC;
                    end
                end
                SYNC: begin
                    w_nextLastVal = din;
                    if (w_match) begin
                        w_nextGood = r_good + 1'b1;
                        if (w_goodDone) begin
                            w_nextState = LOCKED;
                        end
                    end else if (w_odd) begin
                        w_nextGood = '0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
                LOCKED: begin
                    w_nextLastVal = din;
                    if (w_match) begin
                        w_wrapInc = (r_lastVal == ODD_LAST) && (din == ODD_FIRST);
                    end else begin
                        w_nextSeqErr = 1'b1;
                        w_errInc     = 1'b1;
                        if (w_odd) begin
                            w_nextGood  = '0;
                            w_nextState = SYNC;
                        end else begin
                            w_nextState = IDLE;
                        end
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(WRAP_W)
    ) u_wrapCnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_stats),
        .inc  (w_wrapInc),
        .count(wrap_cnt)
    );

    sat_counter #(
        .W(ERR_W)
    ) u_errCnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_stats),
        .inc  (w_errInc),
        .count(err_cnt)
    );

    assign locked   = (r_state == LOCKED);
    assign seq_err  = r_seqErr;
    assign last_val = r_lastVal;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed scoreboard bench for odd_seq_checker (LOCK_LEN=3, 2-bit wrap counter).
// The driver queues a hand-computed expectation per cycle; the monitor pops and compares.
module tb_odd_seq_checker;

    logic       clk;
    logic       reset;
    logic [2:0] din;
    logic       din_valid;
    logic       clr_stats;
    logic       locked;
    logic       seq_err;
    logic [1:0] wrap_cnt;
    logic [7:0] err_cnt;
    logic [2:0] last_val;

    typedef struct {
        int         step;
        logic       locked;
        logic       seqErr;
        logic [1:0] wrap;
        logic [7:0] err;
        logic [2:0] last;
    } exp_t;

    exp_t expQ[$];
    int   stepIdx  = 0;
    int   checks   = 0;
    int   errors   = 0;
    bit   stimDone = 1'b0;

    odd_seq_checker #(
        .LOCK_LEN(3),
        .WRAP_W  (2),
        .ERR_W   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_valid(din_valid),
        .clr_stats(clr_stats),
        .locked   (locked),
        .seq_err  (seq_err),
        .wrap_cnt (wrap_cnt),
        .err_cnt  (err_cnt),
        .last_val (last_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs and queues what the outputs must show after that edge.
    task automatic applyStimulus(input int rst, input int clr, input int v, input int d,
                                 input int eLocked, input int eSeqErr, input int eWrap,
                                 input int eErr, input int eLast);
        exp_t e;
        @(negedge clk);
        reset     = 1'(rst);
        clr_stats = 1'(clr);
        din_valid = 1'(v);
        din       = 3'(d);
        e.step    = stepIdx;
        e.locked  = 1'(eLocked);
        e.seqErr  = 1'(eSeqErr);
        e.wrap    = 2'(eWrap);
        e.err     = 8'(eErr);
        e.last    = 3'(eLast);
        expQ.push_back(e);
        stepIdx++;
    endtask

    // Compares the registered outputs against one queued expectation.
    task automatic checkOutput(input exp_t e);
        checks++;
        if ({locked, seq_err, wrap_cnt, err_cnt, last_val} !==
            {e.locked, e.seqErr, e.wrap, e.err, e.last}) begin
            errors++;
            $display("[TB] FAIL vector %0d: got locked=%0b seq_err=%0b wrap=%0d err=%0d last=%0d, want locked=%0b seq_err=%0b wrap=%0d err=%0d last=%0d",
                     e.step, locked, seq_err, wrap_cnt, err_cnt, last_val,
                     e.locked, e.seqErr, e.wrap, e.err, e.last);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end else if (stimDone) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    // Watchdog so a broken run still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: bench did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed vectors: rst, clr, valid, din -> locked, seq_err, wrap, err, last_val.
    initial begin
        logic [1:0] wBefore;
        reset     = 1'b1;
        clr_stats = 1'b0;
        din_valid = 1'b0;
        din       = 3'd0;

        applyStimulus(1, 0, 0, 0,   0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 5,   0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2,   0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1,   0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 3,   0, 0, 0, 0, 3);
        applyStimulus(0, 0, 1, 5,   0, 0, 0, 0, 5);
        applyStimulus(0, 0, 1, 7,   1, 0, 0, 0, 7);
        applyStimulus(0, 0, 1, 1,   1, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 3,   1, 0, 1, 0, 3);

        applyStimulus(0, 0, 1, 5,   1, 0, 1, 0, 5);
        applyStimulus(0, 0, 1, 7,   1, 0, 1, 0, 7);
        applyStimulus(0, 0, 1, 5,   0, 1, 1, 1, 5);
        applyStimulus(0, 0, 1, 7,   0, 0, 1, 1, 7);
        applyStimulus(0, 0, 1, 1,   0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 3,   1, 0, 1, 1, 3);

        applyStimulus(0, 0, 1, 4,   0, 1, 1, 2, 4);
        applyStimulus(0, 0, 1, 2,   0, 0, 1, 2, 4);
        applyStimulus(0, 0, 1, 3,   0, 0, 1, 2, 3);
        applyStimulus(0, 0, 1, 5,   0, 0, 1, 2, 5);
        applyStimulus(0, 0, 1, 7,   0, 0, 1, 2, 7);
        applyStimulus(0, 0, 1, 1,   1, 0, 1, 2, 1);

        applyStimulus(0, 0, 1, 3,   1, 0, 1, 2, 3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 6,   1, 0, 1, 2, 3);
        end
        applyStimulus(0, 0, 1, 5,   1, 0, 1, 2, 5);

        applyStimulus(0, 0, 1, 5,   0, 1, 1, 3, 5);
        applyStimulus(0, 0, 0, 7,   0, 0, 1, 3, 5);
        applyStimulus(0, 0, 1, 5,   0, 0, 1, 3, 5);
        applyStimulus(0, 0, 1, 6,   0, 0, 1, 3, 6);
        applyStimulus(0, 0, 1, 1,   0, 0, 1, 3, 1);
        applyStimulus(0, 0, 1, 3,   0, 0, 1, 3, 3);
        applyStimulus(0, 0, 1, 7,   0, 0, 1, 3, 7);
        applyStimulus(0, 0, 1, 1,   0, 0, 1, 3, 1);
        applyStimulus(0, 0, 1, 3,   0, 0, 1, 3, 3);
        applyStimulus(0, 0, 1, 5,   1, 0, 1, 3, 5);

        applyStimulus(0, 0, 1, 7,   1, 0, 1, 3, 7);
        applyStimulus(0, 0, 1, 1,   1, 0, 2, 3, 1);
        for (int k = 0; k < 3; k++) begin
            wBefore = (k == 0) ? 2'd2 : 2'd3;
            applyStimulus(0, 0, 1, 3,   1, 0, int'(wBefore), 3, 3);
            applyStimulus(0, 0, 1, 5,   1, 0, int'(wBefore), 3, 5);
            applyStimulus(0, 0, 1, 7,   1, 0, int'(wBefore), 3, 7);
            applyStimulus(0, 0, 1, 1,   1, 0, 3, 3, 1);
        end
        applyStimulus(0, 0, 1, 3,   1, 0, 3, 3, 3);
        applyStimulus(0, 0, 1, 5,   1, 0, 3, 3, 5);
        applyStimulus(0, 0, 1, 7,   1, 0, 3, 3, 7);
        applyStimulus(0, 1, 1, 1,   1, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 3,   1, 0, 0, 0, 3);

        applyStimulus(0, 1, 1, 3,   0, 1, 0, 0, 3);
        applyStimulus(0, 0, 1, 5,   0, 0, 0, 0, 5);
        applyStimulus(0, 0, 1, 7,   0, 0, 0, 0, 7);
        applyStimulus(0, 0, 1, 1,   1, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 3,   1, 0, 0, 0, 3);
        applyStimulus(0, 0, 1, 1,   0, 1, 0, 1, 1);
        applyStimulus(0, 0, 1, 3,   0, 0, 0, 1, 3);
        applyStimulus(0, 0, 1, 5,   0, 0, 0, 1, 5);
        applyStimulus(0, 0, 1, 7,   1, 0, 0, 1, 7);
        applyStimulus(0, 0, 1, 1,   1, 0, 1, 1, 1);

        applyStimulus(1, 0, 1, 3,   0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 3,   0, 0, 0, 0, 3);
        applyStimulus(0, 0, 1, 5,   0, 0, 0, 0, 5);
        applyStimulus(0, 0, 1, 7,   0, 0, 0, 0, 7);
        applyStimulus(0, 0, 1, 1,   1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0,   1, 0, 0, 0, 1);

        stimDone = 1'b1;
    end

endmodule
